mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter DATAWIDTH, default 32: width of the address and data buses.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: wait-cycle limit, used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-003 MEM_ARB_Clk_in  in  1  sole clock; all state updates on its rising edge.
REQ-004 MEM_ARB_Reset_in  in  1  reset, synchronous, active-high.
REQ-005 MEM_ARB_Ins_Read_in  in  1  instruction-fetch request, level, held until Ins_Ready.
REQ-006 MEM_ARB_Ins_Addr_InBUS  in  DATAWIDTH  fetch address.
REQ-007 MEM_ARB_Ins_Readdata_OutBUS  out  DATAWIDTH  fetched word.
REQ-008 MEM_ARB_Ins_Ready_out  out  1  one-cycle fetch-complete pulse.
REQ-009 MEM_ARB_Data_Read_in / MEM_ARB_Data_Write_in  in  1 each  data request, level, held until Data_Ready.
REQ-010 MEM_ARB_Data_Addr_InBUS, MEM_ARB_Data_Writedata_InBUS  in  DATAWIDTH each; MEM_ARB_Data_Byteenable_InBUS  in  4.
REQ-011 MEM_ARB_Data_Readdata_OutBUS  out  DATAWIDTH; MEM_ARB_Data_Ready_out  out  1  one-cycle completion pulse.
REQ-012 MEM_ARB_Mem_Read_out, MEM_ARB_Mem_Write_out  out  1 each; MEM_ARB_Mem_Addr_OutBUS, MEM_ARB_Mem_Writedata_OutBUS  out  DATAWIDTH; MEM_ARB_Mem_Byteenable_OutBUS  out  4.
REQ-013 MEM_ARB_Mem_Readdata_InBUS  in  DATAWIDTH; MEM_ARB_Mem_Ready_in  in  1  memory completes the access in the cycle it is high.
REQ-014 MEM_ARB_Stall_out  out  1  core stall; MEM_ARB_Timeout_out  out  1  sticky timeout flag.

Function
REQ-015 FSM states: IDLE, INS, DATA, DONE; all memory-side outputs are registered.
REQ-016 IDLE, no request: stay in IDLE, Mem_Read/Mem_Write = 0.
REQ-017 IDLE, one requester active: go to INS or DATA and latch address, writedata, byteenable and direction at that edge.
REQ-018 IDLE, both requesters active: grant the port not granted last (last-grant flag); the flag updates on every grant.
REQ-019 Data_Read and Data_Write both high: treated as a write.
REQ-020 INS/DATA: hold latched command on the Mem_* outputs until a cycle with Mem_Ready_in = 1; changes on requester inputs are ignored.
REQ-021 Mem_Ready_in = 1 in INS/DATA: capture Mem_Readdata_InBUS into the granted port's readdata register (reads only), deassert the command, go to DONE.
REQ-022 DONE: exactly one cycle; Ready pulse of the granted port = 1; requests are ignored; next state is IDLE.
REQ-023 Minimum latency: request in IDLE cycle N, command on bus N+1, Mem_Ready_in in N+1, Ready pulse and data valid N+2.
REQ-024 Readdata outputs hold their value until the next completed read on the same port; a write leaves Data_Readdata unchanged.
REQ-025 Byteenable output = latched byteenable for data accesses and 4'b1111 for fetches.
REQ-026 Stall_out = (Ins_Read | Data_Read | Data_Write) & ~(Ins_Ready | Data_Ready), combinational.
REQ-027 A request dropped mid-transaction still completes on the bus and still produces its Ready pulse.

Reset
REQ-028 Reset high at an edge: state = IDLE, all Mem_* outputs = 0, both readdata = 0, both Ready = 0, Timeout = 0, last-grant = INS (first contention grants DATA).
REQ-029 Reset mid-transaction: command deasserts the cycle after the reset edge; no Ready pulse is issued for the aborted access.

Configuration
REQ-030 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit-or-wider wait counter clears on entry to INS/DATA and increments each cycle there without Mem_Ready_in.
REQ-031 When that counter reaches TIMEOUT_CYCLES, the block does the following:
- deasserts the command
- loads 0 into the granted readdata register
- sets Timeout_out until reset
- enters DONE, so the Ready pulse is still issued
REQ-032 Macro undefined: no counter is built, the block waits indefinitely, and Timeout_out is tied to 0.

Verification
REQ-033 Fetch only, addr 0x00000010, Mem_Ready high at first command cycle, readdata 0x00A00093 -> Ins_Ready pulse at N+2, Ins_Readdata = 0x00A00093, Stall low from N+2.
REQ-034 Ins and Data_Read both high after reset -> DATA granted first, then INS; the next simultaneous pair grants DATA again (alternation); each Ready pulses once.
REQ-035 Data_Write addr 0x100, wdata 0xCAFEF00D, byteenable 0011, Mem_Ready delayed 3 cycles -> Mem_Write held 4 cycles with constant addr/data/be, Data_Ready pulse once, Data_Readdata unchanged.
REQ-036 Reset asserted on 2nd wait cycle of a fetch -> Mem_Read = 0 next cycle, no Ins_Ready pulse, all outputs at reset values.
REQ-037 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 4, Mem_Ready never high on Data_Read -> Data_Ready pulse after 4 wait cycles, Data_Readdata = 0, Timeout_out = 1 until reset.
REQ-038 Request held through DONE -> no second grant in DONE; re-grant occurs only from IDLE on the following cycle.

Source files
------------

// File: rtl/mem_arb_if.sv
// mem_arb_if: bus bundle for the two-port memory arbiter.
//   Requester side: instruction fetch port (read only) and data port (read/write),
//   each with a one-cycle Ready completion pulse and a held readdata register.
//   Memory side: registered read/write command, address, writedata and byteenable;
//   the memory returns readdata and a Ready strobe.
//   Status: combinational core stall and sticky timeout flag.
// Modports: slave = arbiter view, master = environment (cores + memory) view.
interface mem_arb_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic                 MEM_ARB_Ins_Read_in;
  logic [DATAWIDTH-1:0] MEM_ARB_Ins_Addr_InBUS;
  logic [DATAWIDTH-1:0] MEM_ARB_Ins_Readdata_OutBUS;
  logic                 MEM_ARB_Ins_Ready_out;

  logic                 MEM_ARB_Data_Read_in;
  logic                 MEM_ARB_Data_Write_in;
  logic [DATAWIDTH-1:0] MEM_ARB_Data_Addr_InBUS;
  logic [DATAWIDTH-1:0] MEM_ARB_Data_Writedata_InBUS;
  logic [3:0]           MEM_ARB_Data_Byteenable_InBUS;
  logic [DATAWIDTH-1:0] MEM_ARB_Data_Readdata_OutBUS;
  logic                 MEM_ARB_Data_Ready_out;

  logic                 MEM_ARB_Mem_Read_out;
  logic                 MEM_ARB_Mem_Write_out;
  logic [DATAWIDTH-1:0] MEM_ARB_Mem_Addr_OutBUS;
  logic [DATAWIDTH-1:0] MEM_ARB_Mem_Writedata_OutBUS;
  logic [3:0]           MEM_ARB_Mem_Byteenable_OutBUS;
  logic [DATAWIDTH-1:0] MEM_ARB_Mem_Readdata_InBUS;
  logic                 MEM_ARB_Mem_Ready_in;

  logic                 MEM_ARB_Stall_out;
  logic                 MEM_ARB_Timeout_out;

  modport slave (
    input  MEM_ARB_Ins_Read_in, MEM_ARB_Ins_Addr_InBUS,
    output MEM_ARB_Ins_Readdata_OutBUS, MEM_ARB_Ins_Ready_out,
    input  MEM_ARB_Data_Read_in, MEM_ARB_Data_Write_in, MEM_ARB_Data_Addr_InBUS,
    input  MEM_ARB_Data_Writedata_InBUS, MEM_ARB_Data_Byteenable_InBUS,
    output MEM_ARB_Data_Readdata_OutBUS, MEM_ARB_Data_Ready_out,
    output MEM_ARB_Mem_Read_out, MEM_ARB_Mem_Write_out, MEM_ARB_Mem_Addr_OutBUS,
    output MEM_ARB_Mem_Writedata_OutBUS, MEM_ARB_Mem_Byteenable_OutBUS,
    input  MEM_ARB_Mem_Readdata_InBUS, MEM_ARB_Mem_Ready_in,
    output MEM_ARB_Stall_out, MEM_ARB_Timeout_out
  );

  modport master (
    output MEM_ARB_Ins_Read_in, MEM_ARB_Ins_Addr_InBUS,
    input  MEM_ARB_Ins_Readdata_OutBUS, MEM_ARB_Ins_Ready_out,
    output MEM_ARB_Data_Read_in, MEM_ARB_Data_Write_in, MEM_ARB_Data_Addr_InBUS,
    output MEM_ARB_Data_Writedata_InBUS, MEM_ARB_Data_Byteenable_InBUS,
    input  MEM_ARB_Data_Readdata_OutBUS, MEM_ARB_Data_Ready_out,
    input  MEM_ARB_Mem_Read_out, MEM_ARB_Mem_Write_out, MEM_ARB_Mem_Addr_OutBUS,
    input  MEM_ARB_Mem_Writedata_OutBUS, MEM_ARB_Mem_Byteenable_OutBUS,
    output MEM_ARB_Mem_Readdata_InBUS, MEM_ARB_Mem_Ready_in,
    input  MEM_ARB_Stall_out, MEM_ARB_Timeout_out
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: arbitrates an instruction-fetch port and a data port onto one memory bus.
//   Ports: MEM_ARB_Clk_in (clock), MEM_ARB_Reset_in (sync active-high reset),
//          bus (mem_arb_if.slave: requester ports, memory port, stall/timeout).
//   Contention alternates between the ports via a last-grant flag; all memory-side
//   outputs, readdata registers and Ready pulses are registered.
//   Optional macro MEM_ARB_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES wait
//   cycles, return zero data, still pulse Ready and set the sticky timeout flag.
module mem_arb #(
  parameter int unsigned DATAWIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic      MEM_ARB_Clk_in,
  input logic      MEM_ARB_Reset_in,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIns, StData, StDone} state_e;

  state_e               state_q, state_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [DATAWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic [DATAWIDTH-1:0] ins_rdata_q, ins_rdata_d;
  logic [DATAWIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                 ins_ready_q, ins_ready_d;
  logic                 data_ready_q, data_ready_d;
  logic                 last_data_q, last_data_d; // 1: last grant went to the data port
  logic                 data_req;

  assign data_req = bus.MEM_ARB_Data_Read_in | bus.MEM_ARB_Data_Write_in;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    ins_rdata_d  = ins_rdata_q;
    data_rdata_d = data_rdata_q;
    ins_ready_d  = 1'b0;
    data_ready_d = 1'b0;
    last_data_d  = last_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
`endif

    case (state_q)
      StIdle: begin
        // Data wins when alone, or under contention if fetch was granted last.
        if (data_req && (!bus.MEM_ARB_Ins_Read_in || !last_data_q)) begin
          state_d     = StData;
          last_data_d = 1'b1;
          // Read+write together is a write.
          mem_write_d = bus.MEM_ARB_Data_Write_in;
          mem_read_d  = !bus.MEM_ARB_Data_Write_in;
          mem_addr_d  = bus.MEM_ARB_Data_Addr_InBUS;
          mem_wdata_d = bus.MEM_ARB_Data_Writedata_InBUS;
          mem_be_d    = bus.MEM_ARB_Data_Byteenable_InBUS;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end else if (bus.MEM_ARB_Ins_Read_in) begin
          state_d     = StIns;
          last_data_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.MEM_ARB_Ins_Addr_InBUS;
          mem_wdata_d = '0;
          mem_be_d    = 4'b1111;
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end
      end
      StIns, StData: begin
        if (bus.MEM_ARB_Mem_Ready_in) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = StDone;
          if (state_q == StIns) begin
            ins_rdata_d = bus.MEM_ARB_Mem_Readdata_InBUS;
            ins_ready_d = 1'b1;
          end else begin
            if (mem_read_q) data_rdata_d = bus.MEM_ARB_Mem_Readdata_InBUS;
            data_ready_d = 1'b1;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // This wait cycle is the TIMEOUT_CYCLES-th one without Ready.
        else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = StDone;
          if (state_q == StIns) begin
            ins_rdata_d = '0;
            ins_ready_d = 1'b1;
          end else begin
            data_rdata_d = '0;
            data_ready_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MEM_ARB_Clk_in) begin
    if (MEM_ARB_Reset_in) begin
      state_q      <= StIdle;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      ins_rdata_q  <= '0;
      data_rdata_q <= '0;
      ins_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      last_data_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      ins_rdata_q  <= ins_rdata_d;
      data_rdata_q <= data_rdata_d;
      ins_ready_q  <= ins_ready_d;
      data_ready_q <= data_ready_d;
      last_data_q  <= last_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bus.MEM_ARB_Mem_Read_out          = mem_read_q;
  assign bus.MEM_ARB_Mem_Write_out         = mem_write_q;
  assign bus.MEM_ARB_Mem_Addr_OutBUS       = mem_addr_q;
  assign bus.MEM_ARB_Mem_Writedata_OutBUS  = mem_wdata_q;
  assign bus.MEM_ARB_Mem_Byteenable_OutBUS = mem_be_q;
  assign bus.MEM_ARB_Ins_Readdata_OutBUS   = ins_rdata_q;
  assign bus.MEM_ARB_Data_Readdata_OutBUS  = data_rdata_q;
  assign bus.MEM_ARB_Ins_Ready_out         = ins_ready_q;
  assign bus.MEM_ARB_Data_Ready_out        = data_ready_q;

  assign bus.MEM_ARB_Stall_out = (bus.MEM_ARB_Ins_Read_in | data_req) &
                                 ~(ins_ready_q | data_ready_q);

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.MEM_ARB_Timeout_out = timeout_q;
`else
  assign bus.MEM_ARB_Timeout_out = 1'b0;
`endif

endmodule
